// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES engine among NREQ requesters:
// accept a job, launch the engine, wait for done or watchdog, return a tagged result.
module aes_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int Nk      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*128-1:0]        req_data,
  input  logic [NREQ*Nk*32-1:0]      req_key,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [127:0]               resp_data,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic                       resp_err,
  output logic                       eng_start,
  output logic [127:0]               eng_data_in,
  output logic [Nk*32-1:0]           eng_key,
  input  logic                       eng_done,
  input  logic [127:0]               eng_data_out,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int KW  = Nk * 32;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and payload is held while valid && !ready.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic            grant_found;
  logic [TW-1:0]   timer;
  logic            accept;
  logic            timed_out;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = wrap_inc(rr_ptr, i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign accept    = (state == IDLE) && grant_found;
  assign timed_out = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    eng_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eng_done || timed_out) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      timer       <= '0;
      resp_data   <= '0;
      resp_id     <= '0;
      resp_err    <= 1'b0;
      eng_data_in <= '0;
      eng_key     <= '0;
    end else begin
      if (accept) begin
        eng_data_in <= req_data[grant_idx*128 +: 128];
        eng_key     <= req_key[grant_idx*KW +: KW];
        resp_id     <= grant_idx;
        rr_ptr      <= wrap_inc(grant_idx, 1);
      end
      // Timer saturates at all-ones so a stuck WAIT can never alias to zero.
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT && timer != '1)
        timer <= timer + 1'b1;
      // Done has priority over a timeout landing in the same cycle.
      if (state == WAIT) begin
        if (eng_done) begin
          resp_data <= eng_data_out;
          resp_err  <= 1'b0;
        end else if (timed_out) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed-plus-random bench for aes_job_scheduler with a behavioural engine
// and a round-robin/latency reference model feeding an expected queue.
module tb_aes_job_scheduler;

  localparam int NREQ    = 4;
  localparam int NK      = 4;
  localparam int TIMEOUT = 255;
  localparam int KW      = NK * 32;
  localparam int IDW     = $clog2(NREQ);
  localparam int W       = 1 + IDW + 128;

  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*128-1:0]   req_data;
  logic [NREQ*KW-1:0]    req_key;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [127:0]          resp_data;
  logic [IDW-1:0]        resp_id;
  logic                  resp_err;
  logic                  eng_start;
  logic [127:0]          eng_data_in;
  logic [KW-1:0]         eng_key;
  logic                  eng_done;
  logic [127:0]          eng_data_out;
  logic                  busy;

  aes_job_scheduler #(.NREQ(NREQ), .Nk(NK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .eng_start(eng_start), .eng_data_in(eng_data_in), .eng_key(eng_key),
    .eng_done(eng_done), .eng_data_out(eng_data_out),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- engine model ----------------
  int           eng_lat = 40;
  int           e_cnt   = 0;
  bit           e_act   = 1'b0;
  logic [127:0] e_d, e_k;
  logic         eng_done_m = 1'b0;
  logic [127:0] eng_out_m  = '0;
  logic         force_done = 1'b0;
  logic [127:0] force_data = '0;

  assign eng_done     = eng_done_m | force_done;
  assign eng_data_out = force_done ? force_data : eng_out_m;

  // Known-answer FIPS-197 case plus a keyed mixing function for other jobs.
  function automatic logic [127:0] eng_model(input logic [127:0] d, input logic [KW-1:0] k);
    if (d == FIPS_P && k == FIPS_K) return FIPS_C;
    return {d[63:0] ^ k[127:64], d[127:64] ^ k[63:0]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  always @(negedge clk) begin
    eng_done_m = 1'b0;
    eng_out_m  = '0;
    if (e_act) begin
      e_cnt++;
      if (e_cnt == eng_lat) begin
        eng_done_m = 1'b1;
        eng_out_m  = eng_model(e_d, e_k);
        e_act      = 1'b0;
      end
    end
    if (eng_start) begin
      e_act = (eng_lat > 0);
      e_cnt = 0;
      e_d   = eng_data_in;
      e_k   = eng_key;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int model_rr = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
    for (int i = 0; i < NREQ; i++)
      if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_req(input int k);
    req_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_key[k*KW +: KW]    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at a negedge with the scheduler idle; returns at a negedge, idle again.
  task automatic do_job(input int lat, input int bp, input bit drop);
    int           g, t_acc, exp_cyc, waited;
    logic [W-1:0] exp, got_exp;
    logic [127:0] d;
    logic [KW-1:0] k;
    bit           bad;
    eng_lat = lat;
    #1;
    g = model_grant(req_valid, model_rr);
    if (g < 0) return;
    d = req_data[g*128 +: 128];
    k = req_key[g*KW +: KW];
    check("req_ready_grant", req_ready, 128'(1) << g);
    t_acc    = cyc;
    model_rr = (g + 1) % NREQ;
    if (lat > 0 && lat <= TIMEOUT) begin
      exp     = {1'b0, IDW'(g), eng_model(d, k)};
      exp_cyc = t_acc + 1 + lat + 1;
    end else begin
      exp     = {1'b1, IDW'(g), 128'h0};
      exp_cyc = t_acc + 1 + TIMEOUT + 1;
    end
    exp_q.push_back(exp);

    @(negedge clk);
    if (drop) req_valid[g] = 1'b0;
    check("eng_start", eng_start, 1);
    check("eng_data_in", eng_data_in, d);
    check("eng_key", eng_key, k);
    @(negedge clk);
    check("eng_start_pulse", eng_start, 0);

    waited = 0;
    bad    = 1'b0;
    while (resp_valid !== 1'b1 && waited < TIMEOUT + 50) begin
      if (req_ready !== '0) bad = 1'b1;
      @(negedge clk);
      waited++;
    end
    got_exp = exp_q.pop_front();
    check("resp_valid_seen", resp_valid, 1);
    check("resp_cycle", cyc, exp_cyc);
    check("req_ready_while_busy", bad, 0);
    check("resp_data", resp_data, got_exp[127:0]);
    check("resp_id", resp_id, got_exp[128 +: IDW]);
    check("resp_err", resp_err, got_exp[W-1]);

    bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== got_exp[127:0] || resp_id !== got_exp[128 +: IDW] ||
          resp_err !== got_exp[W-1] || req_ready !== '0) bad = 1'b1;
    end
    check("resp_hold_stable", bad, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", resp_valid, 0);
    check("busy_after_resp", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit bad;
    rst = 1'b1; req_valid = '0; req_data = '0; req_key = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_data_in", eng_data_in, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: everyone valid, grants must rotate 0,1,2,3,0.
    for (int k = 0; k < NREQ; k++) set_req(k);
    req_valid = '1;
    for (int i = 0; i < 5; i++) do_job(40, 0, 1'b0);
    req_valid = '0;

    // FIPS-197 known answer through requester 0.
    req_data[127:0] = FIPS_P;
    req_key[KW-1:0] = FIPS_K;
    req_valid = NREQ'(1);
    do_job(40, 0, 1'b1);

    // Backpressure held for 20 cycles.
    set_req(1); req_valid = NREQ'(2);
    do_job(40, 20, 1'b1);

    // Engine hang -> timeout error, then a normal job.
    set_req(3); req_valid = NREQ'(8);
    do_job(-1, 0, 1'b1);
    set_req(0); req_valid = NREQ'(1);
    do_job(40, 0, 1'b1);

    // Done exactly on the last timer value wins; one cycle later loses.
    set_req(2); req_valid = NREQ'(4);
    do_job(TIMEOUT, 0, 1'b1);
    set_req(1); req_valid = NREQ'(2);
    do_job(TIMEOUT + 1, 0, 1'b1);

    // Spurious done while idle must not produce a response.
    force_data = {$urandom, $urandom, $urandom, $urandom};
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check("spurious_resp_valid", resp_valid, 0);
    check("spurious_busy", busy, 0);
    @(negedge clk);
    check("spurious_resp_valid_late", resp_valid, 0);

    // Reset in the middle of WAIT; the stale done must be ignored.
    eng_lat = 40;
    set_req(2); req_valid = NREQ'(4);
    #1;
    check("rstwait_req_ready", req_ready, 4);
    @(negedge clk);
    req_valid = '0;
    check("rstwait_eng_start", eng_start, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    check("rstwait_resp_valid", resp_valid, 0);
    check("rstwait_resp_data", resp_data, 0);
    check("rstwait_resp_id", resp_id, 0);
    check("rstwait_resp_err", resp_err, 0);
    check("rstwait_eng_data_in", eng_data_in, 0);
    check("rstwait_eng_key", eng_key, 0);
    check("rstwait_busy", busy, 0);
    bad = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("late_done_ignored", bad, 0);
    set_req(2); set_req(3); req_valid = NREQ'(12);
    do_job(40, 0, 1'b1);
    req_valid = '0;

    // Randomized jobs: masks, payloads, latencies, backpressure.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < NREQ; k++) set_req(k);
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_job(int'($urandom_range(1, 60)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
Round-robin scheduler that shares one AES cipher engine among NREQ independent requesters. It accepts one plaintext/key job at a time over valid/ready handshakes, issues it to the engine with a start pulse, and waits for the engine's done strobe or a watchdog timeout. It then returns the result, tagged with the requester index, over a single valid/ready response channel. It sits between the system-side request ports and the cipher core.

Parameters:
NREQ, 4, number of requesters (2..8)
Nk, 4, key length in 32-bit words; sets key port width
TIMEOUT, 255, engine-wait cycles before job is aborted with error; must exceed engine latency (40 cycles for Nk=4)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester job valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_data  input  NREQ*128  plaintexts; requester k at [k*128 +: 128]
req_key  input  NREQ*Nk*32  keys; requester k at [k*Nk*32 +: Nk*32]
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_data  output  128  ciphertext (0 on error)
resp_id  output  clog2(NREQ)  index of requester owning result
resp_err  output  1  1 = engine timed out
eng_start  output  1  one-cycle launch pulse to engine
eng_data_in  output  128  plaintext to engine, held stable from start until job ends
eng_key  output  Nk*32  key to engine, held stable likewise
eng_done  input  1  engine result-valid strobe
eng_data_out  input  128  engine ciphertext, valid when eng_done=1
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, rr_ptr=0, timer=0; req_ready=0, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, eng_start=0, eng_data_in=0, eng_key=0. Any in-flight job is dropped silently; a later eng_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first index with req_valid=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is combinational: req_ready[g]=1 only in IDLE and only when some req_valid=1; all other bits are 0.
  - On transfer: latch req_data[g], req_key[g] into eng_data_in/eng_key; latch id=g; rr_ptr <= (g+1) mod NREQ; next state ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle; timer <= 0; next state WAIT.
- WAIT: timer increments each cycle.
  - eng_done=1: resp_data <= eng_data_out, resp_err <= 0, go to RESP.
  - Else if timer == TIMEOUT-1: resp_data <= 0, resp_err <= 1, go to RESP.
  - eng_done in the same cycle as timeout: done wins (err=0).
- RESP: resp_valid=1 (registered). resp_data, resp_id and resp_err are held stable until resp_ready=1. On handshake, go to IDLE and drop resp_valid the next cycle. No new request is accepted in RESP, so the accept cycle lands no earlier than one cycle after the response handshake.
- eng_done outside WAIT is ignored.
- Latency: accept at cycle T, eng_start at T+1, resp_valid at cycle D+1 where D is the eng_done cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0...
- A requester deasserting req_valid before acceptance is legal and simply loses its turn.
- Timer width is clog2(TIMEOUT+1). The timer saturates and never wraps.
- Single-clock; no combinational path from resp_ready or eng_done to any output except via registered state. The only combinational output path is req_valid -> req_ready.

Test Plan:
- FIPS-197 vector: req0 with data=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f, bench engine model with 40-cycle done -> eng_start one cycle after accept; resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_err=0.
- All 4 requesters held valid with distinct data, resp_ready=1 -> grant order 0,1,2,3,0; each resp_id matches its source and each data matches the model.
- Engine never asserts done, TIMEOUT=255 -> resp_valid 256 cycles after eng_start cycle+1 with resp_err=1, resp_data=0; scheduler then accepts the next job.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_* stable throughout, req_ready=0 throughout; accepted on the first resp_ready=1.
- eng_done coincident with timer==TIMEOUT-1 -> resp_err=0 and resp_data=eng_data_out; a spurious eng_done in IDLE -> no response.
- rst pulsed mid-WAIT -> all outputs 0 next cycle, rr_ptr=0; a late eng_done produces no resp_valid; the next job from req2 completes normally.
